// File: rtl/systolic_pe_mac_pkg.sv
// systolic_pkg: shared types and helpers for the systolic processing element.
// Holds the accumulate FSM state encoding, the accumulator/length width
// derivations and the dot-product length clamp used when a product starts.
package systolic_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Accumulator wide enough for DIMENSION full-width signed products.
   function automatic int calc_acc_bits(input int i_bits, input int dimension);
      return 2 * i_bits + $clog2(dimension);
   endfunction

   // Length field wide enough to hold the value DIMENSION itself.
   function automatic int calc_len_bits(input int dimension);
      return $clog2(dimension + 1);
   endfunction

   // Requested length 0 behaves as 1; anything above DIMENSION behaves as DIMENSION.
   function automatic int clamp_len(input int len, input int dimension);
      if (len < 1) begin
         return 1;
      end
      if (len > dimension) begin
         return dimension;
      end
      return len;
   endfunction

endpackage

// File: rtl/systolic_pe_mac_round_sat.sv
// pe_round_sat: combinational scale/round/saturate for the PE result.
// The value is arithmetically right-shifted by 'shift' with round-half-up,
// computed one bit wider than the accumulator so the rounding bias cannot
// overflow. With SYSTOLIC_PE_SAT_EN defined the result clamps to the signed
// O_BITS range and flags 'sat'; otherwise it wraps and 'sat' stays 0.
module pe_round_sat #(
   parameter int ACC_BITS   = 18,
   parameter int O_BITS     = 16,
   parameter int SHIFT_BITS = 3
) (
   input  logic [ACC_BITS-1:0]   value,
   input  logic [SHIFT_BITS-1:0] shift,
   output logic [O_BITS-1:0]     result,
   output logic                  sat
);

   localparam int W = ACC_BITS + 1;

   logic signed [W-1:0] ext;
   logic signed [W-1:0] bias;
   logic signed [W-1:0] rounded;

   // Sign-extend, add half an LSB of the scaled result, then shift.
   always_comb begin
      ext  = {value[ACC_BITS-1], value};
      bias = '0;
      if (shift != '0) begin
         bias = W'(1) << (shift - SHIFT_BITS'(1));
      end
      rounded = (ext + bias) >>> shift;
   end

`ifdef SYSTOLIC_PE_SAT_EN
   localparam logic signed [W-1:0] MAX_V = {{(W-O_BITS+1){1'b0}}, {(O_BITS-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_V = {{(W-O_BITS+1){1'b1}}, {(O_BITS-1){1'b0}}};

   // Clamp to the signed output range and report when clamping happened.
   always_comb begin
      result = rounded[O_BITS-1:0];
      sat    = 1'b0;
      if (rounded > MAX_V) begin
         result = MAX_V[O_BITS-1:0];
         sat    = 1'b1;
      end else if (rounded < MIN_V) begin
         result = MIN_V[O_BITS-1:0];
         sat    = 1'b1;
      end
   end
`else
   logic unused_hi;

   // Wrap to the output width; the upper bits are intentionally dropped.
   always_comb begin
      result    = rounded[O_BITS-1:0];
      sat       = 1'b0;
      unused_hi = ^rounded[W-1:O_BITS];
   end
`endif

endmodule

// File: rtl/systolic_pe_mac.sv
// systolic_pe_mac: systolic processing element.
// Forwards A/B to neighbours, accumulates signed products over a runtime
// length (1..DIMENSION) and emits a rounded, scaled result with a one-cycle
// o_c_valid pulse, restarting the next product with no bubble.
// Optional feature macro: SYSTOLIC_PE_SAT_EN (saturate result and drive o_sat).
//
// Handshake: there is no backpressure. i_valid marks an operand pair present
// this cycle and is always consumed; i_clear is a flush token that kills the
// pair it accompanies and any partial sum. o_c_valid is a single-cycle pulse
// that accompanies a new o_c/o_sat; downstream must take it that cycle.
module systolic_pe_mac
   import systolic_pkg::*;
#(
   parameter  int I_BITS     = 8,
   parameter  int DIMENSION  = 4,
   parameter  int O_BITS     = 16,
   parameter  int SHIFT_BITS = 3,
   localparam int ACC_BITS   = calc_acc_bits(I_BITS, DIMENSION),
   localparam int LEN_BITS   = calc_len_bits(DIMENSION)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic                  i_clear,
   input  logic [LEN_BITS-1:0]   i_len,
   input  logic [SHIFT_BITS-1:0] i_shift,
   input  logic [I_BITS-1:0]     i_a,
   input  logic [I_BITS-1:0]     i_b,
   output logic [I_BITS-1:0]     o_a,
   output logic [I_BITS-1:0]     o_b,
   output logic                  o_clear,
   output logic [O_BITS-1:0]     o_c,
   output logic                  o_c_valid,
   output logic                  o_sat,
   output logic                  o_busy
);

   localparam int PROD_BITS = 2 * I_BITS;

   logic signed [PROD_BITS-1:0] prod;
   logic                        p_vld;
   state_t                      state;
   logic [LEN_BITS-1:0]         len_r;
   logic [LEN_BITS-1:0]         count;
   logic [LEN_BITS-1:0]         len_start;
   logic signed [ACC_BITS-1:0]  acc;
   logic signed [ACC_BITS-1:0]  prod_ext;
   logic signed [ACC_BITS-1:0]  acc_in;
   logic signed [ACC_BITS-1:0]  final_sum;
   logic                        finish;
   logic [O_BITS-1:0]           rs_c;
   logic                        rs_sat;

   // Operand forwarding and the multiply stage, which never stalls.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_a     <= '0;
         o_b     <= '0;
         o_clear <= 1'b0;
         prod    <= '0;
         p_vld   <= 1'b0;
      end else begin
         if (i_valid) begin
            o_a <= i_a;
            o_b <= i_b;
         end
         o_clear <= i_clear;
         prod    <= $signed(i_a) * $signed(i_b);
         p_vld   <= i_valid & ~i_clear;
      end
   end

   // Running sum and the finish condition for the product arriving this cycle.
   always_comb begin
      len_start = LEN_BITS'(clamp_len(int'(i_len), DIMENSION));
      prod_ext  = ACC_BITS'(prod);
      acc_in    = (state == ACCUM) ? acc : '0;
      final_sum = acc_in + prod_ext;
      finish    = 1'b0;
      if (p_vld) begin
         if (state == IDLE) begin
            finish = (len_start == LEN_BITS'(1));
         end else begin
            finish = ((count + LEN_BITS'(1)) == len_r);
         end
      end
   end

   pe_round_sat #(
      .ACC_BITS   (ACC_BITS),
      .O_BITS     (O_BITS),
      .SHIFT_BITS (SHIFT_BITS)
   ) u_round_sat (
      .value  (final_sum),
      .shift  (i_shift),
      .result (rs_c),
      .sat    (rs_sat)
   );

   // Accumulate FSM; a finishing product wins over a coincident clear because
   // its pair was already accepted the cycle before.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         len_r     <= '0;
         count     <= '0;
         acc       <= '0;
         o_c       <= '0;
         o_sat     <= 1'b0;
         o_c_valid <= 1'b0;
      end else begin
         o_c_valid <= 1'b0;
         if (finish) begin
            o_c       <= rs_c;
            o_sat     <= rs_sat;
            o_c_valid <= 1'b1;
            acc       <= '0;
            count     <= '0;
            state     <= IDLE;
         end else if (i_clear) begin
            acc   <= '0;
            count <= '0;
            state <= IDLE;
         end else if (p_vld) begin
            case (state)
               IDLE: begin
                  len_r <= len_start;
                  acc   <= final_sum;
                  count <= LEN_BITS'(1);
                  state <= ACCUM;
               end
               ACCUM: begin
                  acc   <= final_sum;
                  count <= count + LEN_BITS'(1);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign o_busy = (count != '0);

endmodule

// File: tb/tb_systolic_pe_mac.sv
// tb_systolic_pe_mac: self-checking bench for systolic_pe_mac.
// Directed cases push known results; a randomised phase uses a small
// reference model. A negedge monitor pops expected results on o_c_valid.
module tb_systolic_pe_mac;

   localparam int I_BITS     = 8;
   localparam int DIMENSION  = 4;
   localparam int O_BITS     = 16;
   localparam int SHIFT_BITS = 3;
   localparam int LEN_BITS   = 3;

   logic                  i_clock;
   logic                  i_reset;
   logic                  i_valid;
   logic                  i_clear;
   logic [LEN_BITS-1:0]   i_len;
   logic [SHIFT_BITS-1:0] i_shift;
   logic [I_BITS-1:0]     i_a;
   logic [I_BITS-1:0]     i_b;
   logic [I_BITS-1:0]     o_a;
   logic [I_BITS-1:0]     o_b;
   logic                  o_clear;
   logic [O_BITS-1:0]     o_c;
   logic                  o_c_valid;
   logic                  o_sat;
   logic                  o_busy;

   int checks = 0;
   int errors = 0;
   logic [O_BITS:0] exp_q[$];

   systolic_pe_mac #(
      .I_BITS     (I_BITS),
      .DIMENSION  (DIMENSION),
      .O_BITS     (O_BITS),
      .SHIFT_BITS (SHIFT_BITS)
   ) dut (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_valid   (i_valid),
      .i_clear   (i_clear),
      .i_len     (i_len),
      .i_shift   (i_shift),
      .i_a       (i_a),
      .i_b       (i_b),
      .o_a       (o_a),
      .o_b       (o_b),
      .o_clear   (o_clear),
      .o_c       (o_c),
      .o_c_valid (o_c_valid),
      .o_sat     (o_sat),
      .o_busy    (o_busy)
   );

   // clock / reset
   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference result for a finished dot product
   function automatic logic [O_BITS:0] model_result(input int sum, input int shift);
      int r;
      r = sum;
      if (shift > 0) begin
         r = (sum + (1 << (shift - 1))) >>> shift;
      end
`ifdef SYSTOLIC_PE_SAT_EN
      if (r > 32767) return {1'b1, 16'h7fff};
      if (r < -32768) return {1'b1, 16'h8000};
      return {1'b0, r[O_BITS-1:0]};
`else
      return {1'b0, r[O_BITS-1:0]};
`endif
   endfunction

   function automatic logic [O_BITS:0] pack_exp(input int c, input logic sat);
      return {sat, c[O_BITS-1:0]};
   endfunction

   // driver tasks: all inputs change just after a falling edge
   task automatic tick();
      @(negedge i_clock);
   endtask

   task automatic drive_pair(input int a, input int b);
      i_valid = 1'b1;
      i_a     = a[I_BITS-1:0];
      i_b     = b[I_BITS-1:0];
      @(negedge i_clock);
      i_valid = 1'b0;
   endtask

   task automatic drive_pair_gap(input int a, input int b);
      drive_pair(a, b);
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic set_cfg(input int len, input int shift);
      tick();
      tick();
      i_len   = len[LEN_BITS-1:0];
      i_shift = shift[SHIFT_BITS-1:0];
   endtask

   // scoreboard monitor
   always @(negedge i_clock) begin
      if (!i_reset && o_c_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_pulse", 32'd1, 32'd0);
         end else begin
            logic [O_BITS:0] e;
            e = exp_q.pop_front();
            check("o_c", 32'(o_c), 32'(e[O_BITS-1:0]));
            check("o_sat", 32'(o_sat), 32'(e[O_BITS]));
         end
      end
   end

   initial begin
      i_reset = 1'b1;
      i_valid = 1'b0;
      i_clear = 1'b0;
      i_len   = '0;
      i_shift = '0;
      i_a     = '0;
      i_b     = '0;
      tick();
      check("rst_o_c", 32'(o_c), 32'd0);
      check("rst_valid", 32'(o_c_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_o_a", 32'(o_a), 32'd0);
      tick();
      i_reset = 1'b0;

      // length 4, shift 0, latency of the result pulse
      set_cfg(4, 0);
      exp_q.push_back(pack_exp(400, 1'b0));
      repeat (4) drive_pair(10, 10);
      check("lat_t", 32'(o_c_valid), 32'd0);
      check("busy_mid", 32'(o_busy), 32'd1);
      tick();
      check("lat_t1", 32'(o_c_valid), 32'd1);
      check("lat_o_c", 32'(o_c), 32'd400);
      tick();
      check("pulse_len", 32'(o_c_valid), 32'd0);
      check("busy_done", 32'(o_busy), 32'd0);

      // back-to-back products, contiguous then with gaps
      set_cfg(2, 0);
      exp_q.push_back(pack_exp(14, 1'b0));
      exp_q.push_back(pack_exp(-30, 1'b0));
      drive_pair(1, 2);
      drive_pair(3, 4);
      drive_pair(-3, 5);
      drive_pair(-3, 5);
      exp_q.push_back(pack_exp(14, 1'b0));
      exp_q.push_back(pack_exp(-30, 1'b0));
      drive_pair_gap(1, 2);
      drive_pair_gap(3, 4);
      drive_pair_gap(-3, 5);
      drive_pair_gap(-3, 5);

      // saturation boundary
      set_cfg(4, 0);
`ifdef SYSTOLIC_PE_SAT_EN
      exp_q.push_back(pack_exp(32767, 1'b1));
`else
      exp_q.push_back(pack_exp(0, 1'b0));
`endif
      repeat (4) drive_pair(-128, -128);

      // rounding half up, length clamping
      set_cfg(1, 1);
      exp_q.push_back(pack_exp(2, 1'b0));
      exp_q.push_back(pack_exp(-1, 1'b0));
      drive_pair(3, 1);
      drive_pair(-3, 1);
      set_cfg(0, 0);
      exp_q.push_back(pack_exp(25, 1'b0));
      exp_q.push_back(pack_exp(-12, 1'b0));
      drive_pair(5, 5);
      drive_pair(-4, 3);
      set_cfg(7, 0);
      exp_q.push_back(pack_exp(24, 1'b0));
      repeat (4) drive_pair(2, 3);

      // clear mid-product
      set_cfg(4, 0);
      drive_pair(7, 7);
      drive_pair(7, 7);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      check("clr_o_clear", 32'(o_clear), 32'd1);
      check("clr_busy", 32'(o_busy), 32'd0);
      tick();
      check("clr_o_clear_off", 32'(o_clear), 32'd0);
      exp_q.push_back(pack_exp(4, 1'b0));
      repeat (4) drive_pair(1, 1);

      // clear coincident with a finishing product still completes it
      set_cfg(2, 0);
      exp_q.push_back(pack_exp(13, 1'b0));
      drive_pair(2, 2);
      drive_pair(3, 3);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;

      // forwarding, hold, then reset while the pulse is high
      set_cfg(1, 0);
      exp_q.push_back(pack_exp(42, 1'b0));
      drive_pair(6, 7);
      check("fwd_a", 32'(o_a), 32'd6);
      check("fwd_b", 32'(o_b), 32'd7);
      tick();
      check("hold_a", 32'(o_a), 32'd6);
      check("pre_rst_valid", 32'(o_c_valid), 32'd1);
      #2 i_reset = 1'b1;
      #1;
      check("arst_valid", 32'(o_c_valid), 32'd0);
      check("arst_o_c", 32'(o_c), 32'd0);
      check("arst_o_a", 32'(o_a), 32'd0);
      check("arst_o_b", 32'(o_b), 32'd0);
      check("arst_busy", 32'(o_busy), 32'd0);
      check("arst_sat", 32'(o_sat), 32'd0);
      tick();
      i_reset = 1'b0;

      // randomised blocks against the reference model
      for (int blk = 0; blk < 24; blk++) begin
         int len;
         int shift;
         int eff;
         len   = $urandom_range(0, 7);
         shift = $urandom_range(0, 7);
         eff   = (len < 1) ? 1 : ((len > DIMENSION) ? DIMENSION : len);
         set_cfg(len, shift);
         for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < eff; k++) begin
               int a;
               int b;
               a = int'($urandom_range(0, 255)) - 128;
               b = int'($urandom_range(0, 255)) - 128;
               sum += a * b;
               if (k == eff - 1) begin
                  exp_q.push_back(model_result(sum, shift));
               end
               drive_pair_gap(a, b);
            end
         end
      end

      // drain with a bounded wait
      for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
         tick();
      end
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
